// File: rtl/store_addr_wr_arb.sv
// Round-robin write arbiter for the store-address prefetch FIFO.
// Packs {id, addr} into the FIFO word and limits per-requester outstanding entries with credit counters.
module store_addr_wr_arb #(
    parameter int N_REQ     = 4,
    parameter int ID_W      = 2,
    parameter int ADDR_W    = 28,
    parameter int MAX_OUTST = 8,
    parameter int CNT_W     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    arb_en,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    fifo_wr_vld,
    output logic                    fifo_wr_en,
    output logic [ID_W+ADDR_W-1:0]  fifo_wr_data,
    input  logic                    done_valid,
    input  logic [ID_W-1:0]         done_id,
    output logic [N_REQ*CNT_W-1:0]  outst_cnt,
    output logic                    busy,
    output logic                    err_underflow
);

    logic [CNT_W-1:0]  cnt      [N_REQ];
    logic [CNT_W-1:0]  cnt_next [N_REQ];
    logic [N_REQ-1:0]  elig;
    logic [N_REQ-1:0]  inc;
    logic [N_REQ-1:0]  dec;
    logic [N_REQ-1:0]  hit;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   probe_idx;
    logic              grant_vld;
    logic [ADDR_W-1:0] sel_addr;
    logic              done_hit_any;
    logic              zero_hit;
    logic              underflow;
    logic              any_next;

    always_comb begin
        elig = '0;
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = req_valid[i] && (cnt[i] < CNT_W'(MAX_OUTST));
        end
    end

    // Search starts at rr_ptr and wraps; grants are masked while reset is held.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        probe_idx = '0;
        if (!rst && arb_en && fifo_wr_vld) begin
            for (int k = 0; k < N_REQ; k++) begin
                probe_idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
                if (!grant_vld && elig[probe_idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = probe_idx;
                end
            end
        end
    end

    always_comb begin
        req_ready    = '0;
        sel_addr     = '0;
        fifo_wr_data = '0;
        if (grant_vld) begin
            req_ready[grant_idx] = 1'b1;
            sel_addr             = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
            fifo_wr_data         = {grant_idx, sel_addr};
        end
    end

    assign fifo_wr_en = grant_vld;

    // A done for an id with no counter, or for a counter already at zero, is an underflow.
    always_comb begin
        inc          = '0;
        dec          = '0;
        hit          = '0;
        done_hit_any = 1'b0;
        zero_hit     = 1'b0;
        any_next     = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            inc[i] = grant_vld && (grant_idx == ID_W'(i));
            hit[i] = done_valid && (done_id == ID_W'(i));
            dec[i] = hit[i] && (cnt[i] != '0);
            if (hit[i]) begin
                done_hit_any = 1'b1;
                if (cnt[i] == '0) begin
                    zero_hit = 1'b1;
                end
            end
            cnt_next[i] = cnt[i];
            if (inc[i] && !dec[i]) begin
                cnt_next[i] = cnt[i] + CNT_W'(1);
            end else if (dec[i] && !inc[i]) begin
                cnt_next[i] = cnt[i] - CNT_W'(1);
            end
            if (cnt_next[i] != '0) begin
                any_next = 1'b1;
            end
        end
        underflow = done_valid && (!done_hit_any || zero_hit);
    end

    always_comb begin
        outst_cnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            outst_cnt[i*CNT_W +: CNT_W] = cnt[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                cnt[i] <= '0;
            end
            rr_ptr        <= '0;
            busy          <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                cnt[i] <= cnt_next[i];
            end
            busy          <= any_next;
            err_underflow <= err_underflow || underflow;
            if (grant_vld) begin
                rr_ptr <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_store_addr_wr_arb.sv
// Directed bench for store_addr_wr_arb: fairness, credit stall, FIFO full,
// grant/done collision, underflow, data packing and reset behaviour.
module tb_store_addr_wr_arb;

    localparam int N_REQ  = 4;
    localparam int ID_W   = 2;
    localparam int ADDR_W = 28;
    localparam int CNT_W  = 4;

    logic                    clk;
    logic                    rst;
    logic                    arb_en;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0]        req_ready;
    logic                    fifo_wr_vld;
    logic                    fifo_wr_en;
    logic [ID_W+ADDR_W-1:0]  fifo_wr_data;
    logic                    done_valid;
    logic [ID_W-1:0]         done_id;
    logic [N_REQ*CNT_W-1:0]  outst_cnt;
    logic                    busy;
    logic                    err_underflow;

    int total;
    int bad;
    logic [ADDR_W-1:0] addrs [N_REQ];

    store_addr_wr_arb #(
        .N_REQ(N_REQ), .ID_W(ID_W), .ADDR_W(ADDR_W), .MAX_OUTST(8), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .arb_en(arb_en),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .fifo_wr_vld(fifo_wr_vld), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .done_valid(done_valid), .done_id(done_id),
        .outst_cnt(outst_cnt), .busy(busy), .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives all inputs and lets the combinational grant path settle.
    task automatic applyStimulus(input logic r, input logic en, input logic [N_REQ-1:0] v,
                                 input logic fv, input logic dv, input logic [ID_W-1:0] did);
        rst         = r;
        arb_en      = en;
        req_valid   = v;
        fifo_wr_vld = fv;
        done_valid  = dv;
        done_id     = did;
        for (int i = 0; i < N_REQ; i++) req_addr[i*ADDR_W +: ADDR_W] = addrs[i];
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < N_REQ; i++) addrs[i] = 28'h0100000 + 28'(i * 'h11);

        // Power-on reset
        applyStimulus(1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd0);
        tick();
        tick();
        checkOutput("rst_cnt", 64'(outst_cnt), 64'h0);
        checkOutput("rst_busy", 64'(busy), 64'h0);
        checkOutput("rst_err", 64'(err_underflow), 64'h0);
        checkOutput("rst_ready", 64'(req_ready), 64'h0);
        checkOutput("rst_wr_en", 64'(fifo_wr_en), 64'h0);

        // Fairness: round-robin order until every requester holds 8 credits
        for (int c = 0; c < 32; c++) begin
            applyStimulus(1'b0, 1'b1, 4'b1111, 1'b1, 1'b0, 2'd0);
            checkOutput("fair_ready", 64'(req_ready), 64'(4'b0001 << (c % 4)));
            checkOutput("fair_data", 64'(fifo_wr_data), 64'({2'(c % 4), addrs[c % 4]}));
            tick();
        end
        applyStimulus(1'b0, 1'b1, 4'b1111, 1'b1, 1'b0, 2'd0);
        checkOutput("fair_stall_ready", 64'(req_ready), 64'h0);
        checkOutput("fair_stall_wr_en", 64'(fifo_wr_en), 64'h0);
        checkOutput("fair_stall_data", 64'(fifo_wr_data), 64'h0);
        checkOutput("fair_cnt", 64'(outst_cnt), 64'h8888);
        checkOutput("fair_busy", 64'(busy), 64'h1);

        // Credit stall: done on 2 frees one credit, requester 2 regrants next cycle
        applyStimulus(1'b0, 1'b1, 4'b1111, 1'b1, 1'b1, 2'd2);
        checkOutput("credit_done_ready", 64'(req_ready), 64'h0);
        tick();
        applyStimulus(1'b0, 1'b1, 4'b1111, 1'b1, 1'b0, 2'd0);
        checkOutput("credit_cnt7", 64'(outst_cnt), 64'h8788);
        checkOutput("credit_regrant", 64'(req_ready), 64'b0100);
        tick();
        checkOutput("credit_cnt8", 64'(outst_cnt), 64'h8888);

        // FIFO full for 5 cycles while credits for 0 and 1 come back
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b0, 1'b1, 4'b1111, 1'b0, (c < 2), 2'(c));
            checkOutput("full_wr_en", 64'(fifo_wr_en), 64'h0);
            tick();
        end
        applyStimulus(1'b0, 1'b1, 4'b1111, 1'b1, 1'b0, 2'd0);
        checkOutput("full_cnt", 64'(outst_cnt), 64'h8877);
        checkOutput("full_release_ready", 64'(req_ready), 64'b0001);
        tick();
        checkOutput("full_release_cnt", 64'(outst_cnt), 64'h8878);

        // Reset mid-burst with counts nonzero and rr_ptr at 1
        applyStimulus(1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0);
        tick();
        applyStimulus(1'b0, 1'b1, 4'b1111, 1'b1, 1'b0, 2'd0);
        checkOutput("midrst_cnt", 64'(outst_cnt), 64'h0);
        checkOutput("midrst_busy", 64'(busy), 64'h0);
        checkOutput("midrst_ready", 64'(req_ready), 64'b0001);
        tick();

        // Build requester 1 up to 3, then collide grant and done on id 1
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 1'b1, 4'b0010, 1'b1, 1'b0, 2'd0);
            tick();
        end
        checkOutput("coll_pre_cnt", 64'(outst_cnt), 64'h0031);
        applyStimulus(1'b0, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1);
        checkOutput("coll_ready", 64'(req_ready), 64'b0010);
        tick();
        checkOutput("coll_cnt", 64'(outst_cnt), 64'h0031);
        checkOutput("coll_err", 64'(err_underflow), 64'h0);

        // Underflow: retire id 0 twice, the second done finds count 0
        applyStimulus(1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd0);
        tick();
        checkOutput("uf_first_cnt", 64'(outst_cnt), 64'h0030);
        checkOutput("uf_first_err", 64'(err_underflow), 64'h0);
        applyStimulus(1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd0);
        tick();
        checkOutput("uf_cnt", 64'(outst_cnt), 64'h0030);
        checkOutput("uf_err", 64'(err_underflow), 64'h1);
        applyStimulus(1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0);
        tick();
        checkOutput("uf_sticky", 64'(err_underflow), 64'h1);

        // Underflow on id 2 together with a grant to 2 still increments to 1
        applyStimulus(1'b0, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2);
        checkOutput("uf_grant_ready", 64'(req_ready), 64'b0100);
        tick();
        checkOutput("uf_grant_cnt", 64'(outst_cnt), 64'h0130);

        // Data packing for requester 3
        addrs[3] = 28'h0ABCDEF;
        applyStimulus(1'b0, 1'b1, 4'b1000, 1'b1, 1'b0, 2'd0);
        checkOutput("pack_ready", 64'(req_ready), 64'b1000);
        checkOutput("pack_wr_en", 64'(fifo_wr_en), 64'h1);
        checkOutput("pack_data", 64'(fifo_wr_data), 64'({2'b11, 28'h0ABCDEF}));
        tick();
        checkOutput("pack_cnt", 64'(outst_cnt), 64'h1130);

        // Global enable low blocks every grant
        applyStimulus(1'b0, 1'b0, 4'b1111, 1'b1, 1'b0, 2'd0);
        checkOutput("arb_dis_ready", 64'(req_ready), 64'h0);
        checkOutput("arb_dis_wr_en", 64'(fifo_wr_en), 64'h0);
        tick();
        checkOutput("arb_dis_cnt", 64'(outst_cnt), 64'h1130);

        // Final reset clears the sticky error
        applyStimulus(1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd0);
        checkOutput("end_err", 64'(err_underflow), 64'h0);
        checkOutput("end_cnt", 64'(outst_cnt), 64'h0);
        checkOutput("end_busy", 64'(busy), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
